if_fetch_unit: RTL and testbench

- Parametrised instruction-fetch stage. Owns the PC and issues fetches to a synchronous instruction memory with 1-cycle read latency.
- Delivers instruction/PC pairs to decode over a valid/ready handshake, using an output register plus a one-entry skid buffer.
- Supports branch/jump redirect with flush of all in-flight and buffered fetches.
- Sits between the PC-select logic/EX redirect path and the IF/ID boundary.

---
 rtl/if_fetch_unit.sv | 122 ++++++++++++
 tb/tb_if_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC and feeds decode through an output register plus a one-entry skid; issue-to-id latency is 2 cycles.
// id_ready low holds id_* and stops issue at two pairs held; build with IF_PERF_CNT_EN for perf_fetch_cnt/perf_redirect_cnt.
module if_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [ILEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_next_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_redirect_cnt
`endif
);

    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(3);

    logic [XLEN-1:0] pc_r;
    logic            inflight;
    logic [XLEN-1:0] inflight_pc;
    logic            skid_valid;
    logic [ILEN-1:0] skid_instr;
    logic [XLEN-1:0] skid_pc;

    logic            drain;
    logic            out_free;
    logic [2:0]      occ;
    logic [XLEN-1:0] redirect_target;

    assign drain           = id_valid & id_ready;
    assign out_free        = ~id_valid | drain;
    assign occ             = {2'b00, id_valid} + {2'b00, skid_valid} + {2'b00, inflight} - {2'b00, drain};
    assign redirect_target = redirect_pc & ~ALIGN_MASK;

    assign imem_addr = pc_r;
    assign imem_req  = ~reset & ~redirect_valid & (occ < 3'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r        <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
            skid_pc     <= '0;
            id_valid    <= 1'b0;
            id_instr    <= '0;
            id_pc       <= '0;
            id_next_pc  <= '0;
        end else if (redirect_valid) begin
            // Flush everything; the response landing now (if any) is dropped.
            pc_r       <= redirect_target;
            inflight   <= 1'b0;
            skid_valid <= 1'b0;
            id_valid   <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc_r        <= pc_r + STEP;
                inflight_pc <= pc_r;
            end

            if (skid_valid) begin
                // Skid is older than any landing response, so it drains first.
                if (out_free) begin
                    id_valid   <= 1'b1;
                    id_instr   <= skid_instr;
                    id_pc      <= skid_pc;
                    id_next_pc <= skid_pc + STEP;
                    skid_valid <= inflight;
                    if (inflight) begin
                        skid_instr <= imem_rdata;
                        skid_pc    <= inflight_pc;
                    end
                end
            end else if (inflight) begin
                if (out_free) begin
                    id_valid   <= 1'b1;
                    id_instr   <= imem_rdata;
                    id_pc      <= inflight_pc;
                    id_next_pc <= inflight_pc + STEP;
                end else begin
                    skid_valid <= 1'b1;
                    skid_instr <= imem_rdata;
                    skid_pc    <= inflight_pc;
                end
            end else if (drain) begin
                id_valid <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetch_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (imem_req) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect_valid) begin
                perf_redirect_cnt <= perf_redirect_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboarded bench for if_fetch_unit: directed phases push expected pcs, a negedge monitor pops on each accepted pair.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_next_pc;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_redirect_cnt;
    int          tb_fetch_cnt = 0;
    int          tb_redirect_cnt = 0;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_next_pc     (id_next_pc)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_redirect_cnt (perf_redirect_cnt)
`endif
    );

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'hA500_0000 ^ (pc >> 2);
    endfunction

    // Synchronous instruction memory, one-cycle read latency.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= instr_of(imem_addr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pc(input logic [31:0] pc, input string name);
        bit found = 0;
        int n = 0;
        while (!found && n < 40) begin
            step();
            n++;
            found = id_valid && (id_pc == pc);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: pc %h not seen within 40 cycles, last id_pc %h", name, pc, id_pc);
        end
    endtask

    // Monitor: every accepted pair must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pair: got pc %h expected none", id_pc);
            end else begin
                exp_pc = exp_q.pop_front();
                chk("id_pc", id_pc, exp_pc);
                chk("id_instr", id_instr, instr_of(exp_pc));
                chk("id_next_pc", id_next_pc, exp_pc + 32'd4);
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always @(negedge clk) begin
        if (reset) begin
            tb_fetch_cnt    = 0;
            tb_redirect_cnt = 0;
        end else begin
            if (imem_req) tb_fetch_cnt++;
            if (redirect_valid) tb_redirect_cnt++;
        end
    end
`endif

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_instr", id_instr, 32'd0);
        chk("rst_id_next_pc", id_next_pc, 32'd0);

        // Streaming from RESET_PC, then a 5-cycle stall at pc 8
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        chk("lat_c0_valid", {31'd0, id_valid}, 32'd0);
        @(negedge clk);
        chk("lat_c1_valid", {31'd0, id_valid}, 32'd0);
        @(negedge clk);
        chk("lat_c2_valid", {31'd0, id_valid}, 32'd1);
        chk("lat_c2_pc", id_pc, 32'h0);

        wait_pc(32'h8, "reach_8");
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, id_valid}, 32'd1);
            chk("stall_pc", id_pc, 32'h8);
            chk("stall_instr", id_instr, instr_of(32'h8));
            chk("stall_no_req", {31'd0, imem_req}, 32'd0);
        end
        @(posedge clk); #1 id_ready = 1'b1;

        // Redirect to 0x100 while stalled with skid full
        wait_pc(32'h20, "reach_20");
        id_ready = 1'b0;
        repeat (3) step();
        chk("q_empty_pre_redirect", 32'(exp_q.size()), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        chk("redir_no_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(i * 4));
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        @(negedge clk);
        chk("redir_r1_valid", {31'd0, id_valid}, 32'd0);
        chk("redir_r1_req", {31'd0, imem_req}, 32'd1);
        chk("redir_r1_addr", imem_addr, 32'h100);
        @(negedge clk);
        chk("redir_r2_valid", {31'd0, id_valid}, 32'd0);
        @(negedge clk);
        chk("redir_r3_valid", {31'd0, id_valid}, 32'd1);
        chk("redir_r3_pc", id_pc, 32'h100);
        wait_pc(32'h110, "reach_110");
        id_ready = 1'b0;

        // Unaligned redirect near the top of the address space, then wrap
        step();
        chk("q_empty_pre_wrap", 32'(exp_q.size()), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF3;
        exp_q.push_back(32'hFFFF_FFF0);
        exp_q.push_back(32'hFFFF_FFF4);
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        @(negedge clk);
        chk("align_addr", imem_addr, 32'hFFFF_FFF0);
        wait_pc(32'h8, "wrap_reach_8");
        id_ready = 1'b0;
        chk("q_empty_post_wrap", 32'(exp_q.size()), 32'd0);
        step();
        chk("wrap_stall_no_req", {31'd0, imem_req}, 32'd0);

        // Reset while stalled with skid occupied
        reset = 1'b1;
        #1;
        chk("midrst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("midrst_id_pc", id_pc, 32'd0);
        chk("midrst_id_instr", id_instr, 32'd0);
        chk("midrst_id_next_pc", id_next_pc, 32'd0);
        chk("midrst_imem_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
        id_ready = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("restart_addr", imem_addr, 32'h0);
        chk("restart_req", {31'd0, imem_req}, 32'd1);
        wait_pc(32'h10, "restart_reach_10");
        id_ready = 1'b0;
        chk("q_empty_end", 32'(exp_q.size()), 32'd0);

`ifdef IF_PERF_CNT_EN
        step();
        chk("perf_fetch_cnt", perf_fetch_cnt, 32'(tb_fetch_cnt));
        chk("perf_redirect_cnt", perf_redirect_cnt, 32'(tb_redirect_cnt));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule
